// File: rtl/simple_and.sv
// Registered two-input AND with a STAGES-deep output pipeline and asynchronous reset.
// Optional input stability filter: define SIMPLE_AND_FILTER_EN.
module simple_and #(
  parameter int   STAGES    = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic ain,
  input  logic bin,
  output logic and_out,
  input  logic clock,
  input  logic reset
);

  if (STAGES < 1 || STAGES > 8) begin : g_stages_check
    $error("simple_and: STAGES must be in 1..8");
  end

  logic              and_s;
  logic              load_s;
  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  assign and_s = ain & bin;

`ifdef SIMPLE_AND_FILTER_EN
  // stage 0 only accepts a value seen on two consecutive edges
  logic hist_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= RESET_VAL;
    end else begin
      hist_q <= and_s;
    end
  end

  assign load_s = (and_s == hist_q);
`else
  assign load_s = 1'b1;
`endif

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = load_s ? and_s : stage_q[0];
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q <= {STAGES{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign and_out = stage_q[STAGES-1];

endmodule

// File: tb/tb_simple_and.sv
// Bench for simple_and: STAGES=1 and STAGES=3 instances against a queue-based reference model.
`timescale 1ns/1ps
module tb_simple_and;

`ifdef SIMPLE_AND_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  localparam logic RV = 1'b0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ain   = 1'b0;
  logic bin   = 1'b0;
  logic and1;
  logic and3;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  simple_and #(.STAGES(1), .RESET_VAL(RV)) dut1 (
    .ain(ain), .bin(bin), .and_out(and1), .clock(clock), .reset(reset)
  );
  simple_and #(.STAGES(3), .RESET_VAL(RV)) dut3 (
    .ain(ain), .bin(bin), .and_out(and3), .clock(clock), .reset(reset)
  );

  always #5 clock = ~clock;

  // Reference: list of values accepted into the pipeline head since the last reset.
  logic samp[$];
  logic filt[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      samp.delete();
      filt.delete();
    end else begin
      logic v, prev, prevf, f;
      v     = ain & bin;
      prev  = (samp.size() > 0) ? samp[samp.size()-1] : RV;
      prevf = (filt.size() > 0) ? filt[filt.size()-1] : RV;
      if (FILT != 0) f = (v == prev) ? v : prevf;
      else           f = v;
      samp.push_back(v);
      filt.push_back(f);
    end
  end

  function automatic logic exp_out(int n);
    int idx;
    idx = filt.size() - n;
    return (idx < 0) ? RV : filt[idx];
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cycle_stages1", and1, exp_out(1));
      chk("cycle_stages3", and3, exp_out(3));
    end
  end

  task automatic drive(input logic a, input logic b);
    @(negedge clock);
    #1;
    ain = a;
    bin = b;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pa, pb;

    // Reset is asynchronous: output cleared before any clock edge
    ain = 1'b1;
    bin = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("reset_async_s1", and1, 1'b0);
    chk("reset_async_s3", and3, 1'b0);
    chk_en = 1'b1;
    edges(2);
    #1;
    chk("reset_held_s1", and1, 1'b0);
    chk("reset_held_s3", and3, 1'b0);

    // Truth table
    drive(1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      pa = p[1];
      pb = p[0];
      drive(pa, pb);
      edges(5);
      #1;
      chk("truth_s1", and1, pa & pb);
      chk("truth_s3", and3, pa & pb);
    end
    chk("model_pin_11", exp_out(1), 1'b1);

    // Mid-run reset between edges, release with inputs high
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset_s1", and1, 1'b0);
    chk("midreset_s3", and3, 1'b0);
    chk("model_pin_reset", exp_out(1), 1'b0);
    @(negedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    chk("release_edge1", and1, (FILT != 0) ? 1'b0 : 1'b1);
    @(posedge clock);
    #1;
    chk("release_edge2", and1, 1'b1);

    // Latency of the three-stage instance, rising and falling step
    drive(1'b0, 1'b0);
    edges(6);
    drive(1'b1, 1'b1);
    for (int k = 1; k <= 3 + FILT; k++) begin
      @(posedge clock);
      #1;
      chk("latency_rise", and3, (k == 3 + FILT) ? 1'b1 : 1'b0);
    end
    edges(2);
    drive(1'b0, 1'b0);
    for (int k = 1; k <= 3 + FILT; k++) begin
      @(posedge clock);
      #1;
      chk("latency_fall", and3, (k == 3 + FILT) ? 1'b0 : 1'b1);
    end

    // Glitch on ain entirely between edges is never sampled
    drive(1'b0, 1'b1);
    edges(4);
    #2 ain = 1'b1;
    #4 ain = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("glitch_s1", and1, 1'b0);
    end

    // One-edge pulse, then a two-edge hold
    drive(1'b0, 1'b0);
    edges(5);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("pulse_edge1", and1, (FILT != 0) ? 1'b0 : 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("pulse_after", and1, 1'b0);
    end
    drive(1'b1, 1'b1);
    @(posedge clock);
    #1;
    chk("hold_edge1", and1, (FILT != 0) ? 1'b0 : 1'b1);
    @(posedge clock);
    #1;
    chk("hold_edge2", and1, 1'b1);

    // Random traffic with occasional off-edge resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rand_reset_s1", and1, RV);
        chk("rand_reset_s3", and3, RV);
        @(negedge clock);
        #2 reset = 1'b0;
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    edges(2);
    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
